// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane, periodic leak, polarity-selected spike, refractory hold.
// Optional spike counter (cnt_clr / spike_count) is enabled by defining LIF_SPIKE_COUNT_EN.
module lif_neuron #(
    parameter int N_IN        = 4,
    parameter int CNT_W       = 8,
    parameter int REFRAC      = 2,
    parameter int LEAK_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_IN-1:0]  pos_in,
    input  logic [N_IN-1:0]  neg_in,
    input  logic [CNT_W-1:0] threshold,
    input  logic             weight,
`ifdef LIF_SPIKE_COUNT_EN
    input  logic             cnt_clr,
    output logic [15:0]      spike_count,
`endif
    output logic             pos_out,
    output logic             neg_out,
    output logic [CNT_W-1:0] membrane,
    output logic             refrac
);

    // state      | meaning
    // INTEG      | integrating inputs and leak, may fire
    // REFRACTORY | inputs ignored, membrane held at 0 for REFRAC cycles

    localparam int SW   = CNT_W + 2;
    localparam int LK_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RC_W = (REFRAC > 1) ? $clog2(REFRAC) : 1;
    localparam logic [LK_W-1:0] LEAK_LAST = (LEAK_PERIOD > 0) ? LK_W'(LEAK_PERIOD - 1) : '0;
    localparam logic [RC_W-1:0] RC_LOAD   = (REFRAC > 0) ? RC_W'(REFRAC - 1) : '0;
    localparam logic signed [SW-1:0] MAX_S = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic {INTEG, REFRACTORY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  mem_d;
    logic [LK_W-1:0]   leak_q, leak_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic              pos_d, neg_d;
    logic              leak;
    logic              fire;
    logic signed [SW-1:0] sum;
    logic [CNT_W-1:0]  next_mem;

    function automatic logic signed [SW-1:0] popcount(input logic [N_IN-1:0] v);
        logic signed [SW-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + {{(SW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INTEG;
            membrane <= '0;
            leak_q   <= '0;
            rc_q     <= '0;
            pos_out  <= 1'b0;
            neg_out  <= 1'b0;
        end else begin
            state_q  <= state_d;
            membrane <= mem_d;
            leak_q   <= leak_d;
            rc_q     <= rc_d;
            pos_out  <= pos_d;
            neg_out  <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_d    = membrane;
        leak_d   = leak_q;
        rc_d     = rc_q;
        pos_d    = 1'b0;
        neg_d    = 1'b0;
        next_mem = '0;
        leak     = (LEAK_PERIOD > 0) && (leak_q == LEAK_LAST);

        // Extra two bits let the raw sum swing below 0 and above the max before clamping.
        sum = $signed({2'b00, membrane}) + popcount(pos_in) - popcount(neg_in)
              - $signed({{(SW-1){1'b0}}, leak});
        if (sum < 0)
            next_mem = '0;
        else if (sum > MAX_S)
            next_mem = '1;
        else
            next_mem = sum[CNT_W-1:0];

        fire = (threshold != '0) && (next_mem >= threshold);

        if (en) begin
            case (state_q)
                INTEG: begin
                    if (fire) begin
                        mem_d  = '0;
                        leak_d = '0;
                        if (weight) pos_d = 1'b1;
                        else        neg_d = 1'b1;
                        if (REFRAC > 0) begin
                            state_d = REFRACTORY;
                            rc_d    = RC_LOAD;
                        end
                    end else begin
                        mem_d = next_mem;
                        if (LEAK_PERIOD > 0)
                            leak_d = leak ? '0 : leak_q + LK_W'(1);
                    end
                end
                REFRACTORY: begin
                    if (rc_q == '0) state_d = INTEG;
                    else            rc_d    = rc_q - RC_W'(1);
                end
                default: state_d = INTEG;
            endcase
        end
    end

    assign refrac = (state_q == REFRACTORY);

`ifdef LIF_SPIKE_COUNT_EN
    logic fire_evt;
    assign fire_evt = en && (state_q == INTEG) && fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spike_count <= '0;
        else if (cnt_clr)
            spike_count <= '0;
        else if (fire_evt && (spike_count != 16'hFFFF))
            spike_count <= spike_count + 16'd1;
    end
`endif

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Parametrised leaky integrate-and-fire neuron, successor to the single-input spike counter neuron. Integrates N_IN excitatory and N_IN inhibitory spike lanes per clock into a saturating membrane counter, applies periodic leak, fires a one-cycle spike on the polarity selected by `weight`, then enforces a refractory period. Instantiated per neuron inside the SNN layer arrays; fully synchronous to `clk`.

## Interface
- `N_IN`, 4: spike lanes per polarity (1..16)
- `CNT_W`, 8: membrane and threshold width (4..16)
- `REFRAC`, 2: refractory cycles after a fire; 0 = none
- `LEAK_PERIOD`, 4: integrate cycles per leak decrement of 1; 0 = leak disabled

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  integration enable; low freezes all state
- `pos_in`  in  N_IN  excitatory spikes, one bit per lane, sampled every cycle
- `neg_in`  in  N_IN  inhibitory spikes
- `threshold`  in  CNT_W  fire threshold, sampled every cycle; 0 disables firing
- `weight`  in  1  output polarity: 1 → `pos_out`, 0 → `neg_out`
- `pos_out`  out  1  excitatory spike pulse, registered
- `neg_out`  out  1  inhibitory spike pulse, registered
- `membrane`  out  CNT_W  current membrane value, registered
- `refrac`  out  1  high while in REFRACTORY

## Operation
- States: INTEG, REFRACTORY. Reset → INTEG, membrane 0, leak counter 0, refractory counter 0, all outputs 0.
- INTEG, `en`=1: net = popcount(`pos_in`) − popcount(`neg_in`) − leak, computed signed at CNT_W+2 bits; leak = 1 on the cycle the leak counter equals LEAK_PERIOD−1, else 0. Leak counter wraps to 0 on that cycle.
- next = membrane + net, clamped to [0, 2^CNT_W−1]. No wrap in either direction.
- Fire when `threshold` ≠ 0 and next ≥ `threshold`: membrane ← 0, leak counter ← 0, pulse the output chosen by `weight`, enter REFRACTORY if REFRAC > 0, else stay in INTEG.
- No fire: membrane ← next.
- REFRACTORY: `pos_in`/`neg_in` ignored, no leak, membrane held at 0, counter runs REFRAC cycles then returns to INTEG.
- `en`=0: state, membrane, leak counter and refractory counter hold. Spike outputs return to 0.
- `weight` and `threshold` are used as sampled in the firing cycle. Both outputs are never high together.

## Timing
- Inputs sampled at edge k. Resulting `membrane` visible after edge k. A fire decided at edge k asserts the spike output for exactly the cycle after edge k.
- Refractory: inputs at edges k+1..k+REFRAC discarded. First integrated input is at edge k+REFRAC+1. `refrac` is high for exactly REFRAC cycles.
- REFRAC=0: back-to-back fires on consecutive cycles are legal.
- Leak and input on the same cycle combine in one update. Leak at membrane 0 has no effect.
- Reset mid-REFRACTORY or mid-pulse: outputs drop to 0 immediately, asynchronously. After release, first integration is at the first rising edge with `rst_n`=1.

## Configuration
- `LIF_SPIKE_COUNT_EN` defined: adds input `cnt_clr` (1b, synchronous) and output `spike_count` (16b).
  - `spike_count` increments on each fire and saturates at 16'hFFFF.
  - `cnt_clr` zeroes the count. Clear wins over an increment in the same cycle.
  - Reset value is 0.
- Not defined: neither port exists and no counter logic is present. All other behaviour is identical.

## Test plan
- Defaults, `threshold`=5, `weight`=1, `pos_in`=4'b0111 for 2 cycles:
  - membrane 3, then next=6 ≥ 5, so fire.
  - `pos_out`=1 for one cycle, membrane 0, `refrac` high 2 cycles.
  - `neg_out` stays 0 throughout.
- Saturation:
  - `threshold`=0, `pos_in`=4'hF for 70 cycles with LEAK_PERIOD=0: membrane sticks at 255.
  - Then `neg_in`=4'hF for 70 cycles: membrane sticks at 0, no wrap.
- Leak: LEAK_PERIOD=4, membrane preloaded to 3 via inputs, then idle inputs: membrane decrements by 1 every 4 cycles to 0 and holds.
- Refractory: REFRAC=3, fire with `weight`=0, then `pos_in`=4'hF continuously:
  - `neg_out` pulses once.
  - Inputs during the 3 refractory cycles are ignored.
  - Membrane reads 4 one cycle after refractory ends.
- `en` low for 5 cycles mid-integration, then `rst_n` low mid-REFRACTORY:
  - While `en` is low, membrane and `refrac` freeze.
  - On reset, all outputs are 0 immediately and membrane is 0 after release.
- With `LIF_SPIKE_COUNT_EN`:
  - 3 fires give `spike_count`=3.
  - `cnt_clr` asserted in the same cycle as a 4th fire gives 0.
